// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature report controller.
package temp_pkg;

  localparam int unsigned TEMP_W     = 7;
  localparam int unsigned TEMP_MAX   = 99;
  localparam int unsigned HS_TIMEOUT = 4;

  typedef enum logic [2:0] {
    WAIT,
    ARM,
    FIRE,
    RISE,
    FALL
  } rpt_state_t;

endpackage

// File: rtl/temp_avg.sv
// Block averager: sums 2**AVG_LOG2 samples, emits the clamped mean plus a one-cycle strobe.
module temp_avg
  import temp_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] sample_data,
  output logic [TEMP_W-1:0] avg,
  output logic              avg_stb,
  output logic              avg_valid
);

  localparam int unsigned ACC_W = TEMP_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TEMP_W-1:0] avg_q, avg_d;
  logic              stb_q, stb_d;
  logic              valid_q, valid_d;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  quot;

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    avg_d   = avg_q;
    stb_d   = 1'b0;
    valid_d = valid_q;
    sum     = acc_q + ACC_W'(sample_data);
    quot    = sum >> AVG_LOG2;
    if (sample_valid) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        // Final sample of the block closes the average and restarts accumulation.
        avg_d   = (quot > ACC_W'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : TEMP_W'(quot);
        acc_d   = '0;
        cnt_d   = '0;
        stb_d   = 1'b1;
        valid_d = 1'b1;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
      stb_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      avg_q   <= avg_d;
      stb_q   <= stb_d;
      valid_q <= valid_d;
    end
  end

  assign avg       = avg_q;
  assign avg_stb   = stb_q;
  assign avg_valid = valid_q;

endmodule

// File: rtl/temp_report_ctrl.sv
// Feeds the UART temperature transmitter: periodic and alarm-driven reports with a
// start/busy handshake and a sticky handshake-timeout flag.
module temp_report_ctrl
  import temp_pkg::*;
#(
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned REPORT_PERIOD = 50000,
  parameter int unsigned ALARM_HI      = 80,
  parameter int unsigned ALARM_LO      = 75
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              sample_valid,
  input  logic [TEMP_W-1:0] sample_data,
  input  logic              busy,
  output logic              start,
  output logic [TEMP_W-1:0] temp,
  output logic              alarm,
  output logic              avg_valid,
  output logic              hs_err
);

  localparam int unsigned TMR_W = $clog2(REPORT_PERIOD);
  localparam int unsigned HS_W  = $clog2(HS_TIMEOUT);

  logic [TEMP_W-1:0] avg;
  logic              avg_stb;

  rpt_state_t        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [HS_W-1:0]   hs_cnt_q, hs_cnt_d;
  logic              due_q, due_d;
  logic              alarm_q, alarm_d;
  logic              start_q, start_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic              hs_err_q, hs_err_d;
  logic              wrap, alarm_rise, due_clr;

  temp_avg #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .nRST         (nRST),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .avg          (avg),
    .avg_stb      (avg_stb),
    .avg_valid    (avg_valid)
  );

  always_comb begin
    wrap       = (timer_q == TMR_W'(REPORT_PERIOD - 1));
    timer_d    = wrap ? '0 : timer_q + TMR_W'(1);
    alarm_d    = alarm_q;
    alarm_rise = 1'b0;
    state_d    = state_q;
    start_d    = 1'b0;
    temp_d     = temp_q;
    hs_err_d   = hs_err_q;
    hs_cnt_d   = hs_cnt_q;
    due_clr    = 1'b0;

    // Hysteresis is only re-evaluated when a fresh average lands.
    if (avg_stb) begin
      if (!alarm_q && (avg >= TEMP_W'(ALARM_HI))) begin
        alarm_d    = 1'b1;
        alarm_rise = 1'b1;
      end else if (alarm_q && (avg <= TEMP_W'(ALARM_LO))) begin
        alarm_d = 1'b0;
      end
    end

    case (state_q)
      WAIT: if (due_q && avg_valid) state_d = ARM;
      ARM: begin
        // start and temp are loaded together so temp only moves in the start cycle.
        if (!busy) begin
          state_d = FIRE;
          start_d = 1'b1;
          temp_d  = avg;
        end
      end
      FIRE: begin
        due_clr  = 1'b1;
        hs_cnt_d = '0;
        state_d  = RISE;
      end
      RISE: begin
        if (busy) begin
          state_d = FALL;
        end else if (hs_cnt_q == HS_W'(HS_TIMEOUT - 1)) begin
          hs_err_d = 1'b1;
          state_d  = WAIT;
        end else begin
          hs_cnt_d = hs_cnt_q + HS_W'(1);
        end
      end
      FALL:    if (!busy) state_d = WAIT;
      default: state_d = WAIT;
    endcase

    // A new due event in the clearing cycle wins; repeated events collapse into one.
    due_d = (wrap || alarm_rise) ? 1'b1 : (due_clr ? 1'b0 : due_q);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q  <= WAIT;
      timer_q  <= '0;
      hs_cnt_q <= '0;
      due_q    <= 1'b0;
      alarm_q  <= 1'b0;
      start_q  <= 1'b0;
      temp_q   <= '0;
      hs_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hs_cnt_q <= hs_cnt_d;
      due_q    <= due_d;
      alarm_q  <= alarm_d;
      start_q  <= start_d;
      temp_q   <= temp_d;
      hs_err_q <= hs_err_d;
    end
  end

  assign start  = start_q;
  assign temp   = temp_q;
  assign alarm  = alarm_q;
  assign hs_err = hs_err_q;

endmodule
